// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and sizes for the mux scan sequencer.
package mux_scan_pkg;

   localparam int CHAN_N   = 4;
   localparam int SEL_W    = 2;
   localparam int SETTLE_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } scan_state_e;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Scan control, mux feedback and snapshot handshake bundle.
interface mux_scan_ctrl_if #(
   parameter int CNT_W = 8
);
   import mux_scan_pkg::*;

   logic              start;
   logic              abort;
   logic              cont;
   logic [CHAN_N-1:0] chan_mask;
   logic              y_in;
   logic [SEL_W-1:0]  s;
   logic              busy;
   logic [CHAN_N-1:0] snap;
   logic              snap_valid;
   logic              snap_ready;
   logic [CNT_W-1:0]  scan_count;

   modport master (
      input  start, abort, cont, chan_mask, y_in, snap_ready,
      output s, busy, snap, snap_valid, scan_count
   );

   modport slave (
      output start, abort, cont, chan_mask, y_in, snap_ready,
      input  s, busy, snap, snap_valid, scan_count
   );

endinterface

// File: rtl/mux_scan_ctrl_next_chan.sv
// Picks the next enabled mux channel: lowest enabled, or lowest enabled above cur.
module mux_next_chan
   import mux_scan_pkg::*;
(
   input  logic [CHAN_N-1:0] mask,
   input  logic [SEL_W-1:0]  cur,
   input  logic              first,
   output logic [SEL_W-1:0]  nxt,
   output logic              found
);

   // Descending walk so the lowest qualifying channel is the last one written.
   always_comb begin
      nxt   = '0;
      found = 1'b0;
      for (int i = CHAN_N - 1; i >= 0; i--) begin
         if (mask[i] && (first || (SEL_W'(i) > cur))) begin
            nxt   = SEL_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Mux scan sequencer: steps s over enabled channels, samples y_in after a
// settle time and hands the 4-bit snapshot downstream on valid/ready.
//
// state  | meaning
// IDLE   | no scan; waits for start
// SETTLE | s driven, settle counter running toward sample point
// HOLD   | snapshot presented, waiting for snap_ready
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   mux_scan_ctrl_if.master bus
);

   localparam logic [SETTLE_W-1:0] SETTLE_RELOAD = SETTLE_W'(SETTLE_CYCLES - 1);

   scan_state_e       state_q, state_d;
   logic [SEL_W-1:0]  s_q, s_d;
   logic [SETTLE_W-1:0] cnt_q, cnt_d;
   logic [CHAN_N-1:0] mask_q, mask_d;
   logic [CHAN_N-1:0] shadow_q, shadow_d;
   logic [CHAN_N-1:0] snap_q, snap_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              nc_first;
   logic [CHAN_N-1:0] nc_mask;
   logic [SEL_W-1:0]  nc_nxt;
   logic              nc_found;
   logic [CHAN_N-1:0] merged;
   logic              launch;

   // Outside SETTLE the search always looks for the first channel of a new scan.
   assign nc_first = (state_q != SETTLE);
   assign nc_mask  = nc_first ? bus.chan_mask : mask_q;

   mux_next_chan u_next_chan (
      .mask  (nc_mask),
      .cur   (s_q),
      .first (nc_first),
      .nxt   (nc_nxt),
      .found (nc_found)
   );

   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      cnt_d    = cnt_q;
      mask_d   = mask_q;
      shadow_d = shadow_q;
      snap_d   = snap_q;
      count_d  = count_q;
      launch   = 1'b0;
      merged   = shadow_q;
      merged[s_q] = bus.y_in;

      case (state_q)
         IDLE: begin
            if (bus.start) launch = 1'b1;
         end
         SETTLE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - SETTLE_W'(1);
            end else begin
               shadow_d = merged;
               if (nc_found) begin
                  s_d   = nc_nxt;
                  cnt_d = SETTLE_RELOAD;
               end else begin
                  snap_d  = merged;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (bus.snap_ready) begin
               count_d = count_q + CNT_W'(1);
               if (bus.cont) launch = 1'b1;
               else          state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (launch) begin
         mask_d   = bus.chan_mask;
         shadow_d = '0;
         if (nc_found) begin
            s_d     = nc_nxt;
            cnt_d   = SETTLE_RELOAD;
            state_d = SETTLE;
         end else begin
            snap_d  = '0;
            state_d = HOLD;
         end
      end

      // Abort overrides everything else decided on this edge.
      if (bus.abort) begin
         state_d  = IDLE;
         s_d      = s_q;
         cnt_d    = cnt_q;
         mask_d   = mask_q;
         shadow_d = shadow_q;
         snap_d   = snap_q;
         count_d  = count_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         s_q      <= '0;
         cnt_q    <= '0;
         mask_q   <= '0;
         shadow_q <= '0;
         snap_q   <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         s_q      <= s_d;
         cnt_q    <= cnt_d;
         mask_q   <= mask_d;
         shadow_q <= shadow_d;
         snap_q   <= snap_d;
         count_q  <= count_d;
      end
   end

   assign bus.s          = s_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.snap_valid = (state_q == HOLD);
   assign bus.snap       = snap_q;
   assign bus.scan_count = count_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: stimulus pushes expected snapshots,
// a negedge monitor pops and compares each presented snapshot.
module tb_mux_scan_ctrl;
   import mux_scan_pkg::*;

   localparam int S = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mux_scan_ctrl_if #(.CNT_W(8)) bus ();
   logic [3:0] d_mux;
   assign bus.y_in = d_mux[bus.s];

   mux_scan_ctrl #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [3:0] snap;
      int         cyc;
   } exp_t;
   exp_t exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s: timed out (t=%0t)", name, $time);
   endtask

   // Monitor: a new snapshot is presented when valid rises or follows an accept.
   logic [7:0] exp_count;
   logic       prev_valid, prev_acc;
   logic [3:0] last_snap;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         exp_count  = '0;
         prev_valid = 1'b0;
         prev_acc   = 1'b0;
      end else begin
         if (bus.snap_valid && (!prev_valid || prev_acc)) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_snap", 32'(bus.snap_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               last_snap = e.snap;
               check("sb_snap", 32'(bus.snap), 32'(e.snap));
               check("sb_latency", 32'(cyc), 32'(e.cyc));
               check("sb_count", 32'(bus.scan_count), 32'(exp_count));
            end
         end else if (bus.snap_valid) begin
            check("sb_hold_snap", 32'(bus.snap), 32'(last_snap));
         end
         prev_acc   = bus.snap_valid && bus.snap_ready;
         prev_valid = bus.snap_valid;
         if (prev_acc) exp_count = exp_count + 8'd1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_scan(input logic [3:0] m, input logic [3:0] d,
                             input bit push, output int e);
      exp_t x;
      d_mux         = d;
      bus.chan_mask = m;
      bus.start     = 1'b1;
      e             = cyc + 1;
      if (push) begin
         x.snap = m & d;
         x.cyc  = e + $countones(m) * S;
         exp_q.push_back(x);
      end
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         if (bus.snap_valid) got = 1'b1;
         else tick();
      end
      if (!got) timeout(name);
   endtask

   task automatic accept();
      bus.snap_ready = 1'b1;
      tick();
      bus.snap_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int e, tgt, nxt_e;
      logic [3:0] m, d;
      logic [1:0] sparse_seq [4];
      exp_t x;
      bit done;

      rst_n = 1'b0;
      bus.start = 1'b0; bus.abort = 1'b0; bus.cont = 1'b0;
      bus.chan_mask = '0; bus.snap_ready = 1'b0; d_mux = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      check("rst_s", 32'(bus.s), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_snap", 32'(bus.snap), 32'd0);
      check("rst_valid", 32'(bus.snap_valid), 32'd0);
      check("rst_count", 32'(bus.scan_count), 32'd0);

      // Full scan, then 10 cycles of backpressure.
      start_scan(4'hF, 4'hA, 1'b1, e);
      for (int k = 0; k < 8; k++) begin
         check("full_s_seq", 32'(bus.s), 32'(k / S));
         check("full_busy", 32'(bus.busy), 32'd1);
         tick();
      end
      check("full_valid", 32'(bus.snap_valid), 32'd1);
      check("full_snap", 32'(bus.snap), 32'hA);
      for (int k = 0; k < 10; k++) begin
         tick();
         check("bp_valid", 32'(bus.snap_valid), 32'd1);
         check("bp_snap", 32'(bus.snap), 32'hA);
         check("bp_s", 32'(bus.s), 32'd3);
         check("bp_busy", 32'(bus.busy), 32'd1);
      end
      accept();
      check("full_acc_valid", 32'(bus.snap_valid), 32'd0);
      check("full_acc_busy", 32'(bus.busy), 32'd0);
      check("full_acc_count", 32'(bus.scan_count), 32'd1);

      // Sparse mask visits only channels 0 and 2.
      sparse_seq = '{2'd0, 2'd0, 2'd2, 2'd2};
      start_scan(4'h5, 4'hF, 1'b1, e);
      for (int k = 0; k < 4; k++) begin
         check("sparse_s_seq", 32'(bus.s), 32'(sparse_seq[k]));
         tick();
      end
      check("sparse_valid", 32'(bus.snap_valid), 32'd1);
      check("sparse_snap", 32'(bus.snap), 32'h5);
      accept();
      check("sparse_count", 32'(bus.scan_count), 32'd2);

      // Empty mask completes one edge after start.
      start_scan(4'h0, 4'(($urandom)), 1'b1, e);
      check("empty_valid", 32'(bus.snap_valid), 32'd1);
      check("empty_snap", 32'(bus.snap), 32'd0);
      check("empty_busy", 32'(bus.busy), 32'd1);
      accept();
      check("empty_count", 32'(bus.scan_count), 32'd3);

      // Abort together with start mid-scan.
      start_scan(4'hF, 4'(($urandom)), 1'b0, e);
      tick(); tick();
      bus.abort = 1'b1; bus.start = 1'b1; bus.chan_mask = 4'(($urandom));
      tick();
      bus.abort = 1'b0; bus.start = 1'b0;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_valid", 32'(bus.snap_valid), 32'd0);
      check("abort_s", 32'(bus.s), 32'd1);
      check("abort_count", 32'(bus.scan_count), 32'd3);
      tick();
      check("abort_stays_idle", 32'(bus.busy), 32'd0);

      // Abort while the snapshot is held.
      d = 4'(($urandom));
      start_scan(4'h3, d, 1'b1, e);
      wait_valid("abort_hold_wait");
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("abort_hold_valid", 32'(bus.snap_valid), 32'd0);
      check("abort_hold_busy", 32'(bus.busy), 32'd0);
      check("abort_hold_snap", 32'(bus.snap), 32'(d & 4'h3));
      check("abort_hold_count", 32'(bus.scan_count), 32'd3);

      // Randomized scans with random backpressure and mask churn.
      for (int n = 0; n < 40; n++) begin
         m = 4'(($urandom));
         d = 4'(($urandom));
         start_scan(m, d, 1'b1, e);
         done = 1'b0;
         for (int i = 0; i < 200 && !done; i++) begin
            bus.snap_ready = ($urandom_range(0, 2) != 0);
            bus.chan_mask  = 4'(($urandom));
            tick();
            if (!bus.busy) done = 1'b1;
         end
         bus.snap_ready = 1'b0;
         if (!done) timeout("rand_scan_done");
      end

      // Reset mid-scan clears outputs immediately.
      start_scan(4'hF, 4'(($urandom)), 1'b0, e);
      tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_s", 32'(bus.s), 32'd0);
      check("rst_mid_busy", 32'(bus.busy), 32'd0);
      check("rst_mid_valid", 32'(bus.snap_valid), 32'd0);
      check("rst_mid_count", 32'(bus.scan_count), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("rst_mid_idle", 32'(bus.busy), 32'd0);

      // Continuous mode, ready tied high: 260 scans wrap the counter.
      d = 4'(($urandom));
      bus.cont = 1'b1;
      bus.snap_ready = 1'b1;
      start_scan(4'h1, d, 1'b1, e);
      for (int k = 0; k < 260; k++) begin
         tgt = e + S;
         while (cyc < tgt) tick();
         nxt_e = tgt + 1;
         if (k == 259) begin
            bus.cont = 1'b0;
         end else begin
            x.snap = d & 4'h1;
            x.cyc  = nxt_e + S;
            exp_q.push_back(x);
         end
         e = nxt_e;
      end
      repeat (3) tick();
      bus.snap_ready = 1'b0;
      check("cont_end_busy", 32'(bus.busy), 32'd0);
      check("cont_end_count", 32'(bus.scan_count), 32'd4);
      check("sb_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
